// File: rtl/dram_march_ctrl.sv
// March-style LUT-RAM tester: writes P(a) then ~P(a) over 0..MAX_ADDRESS,
// reading back each phase and reporting every mismatch as a held error record.
module dram_march_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 6,
  parameter int MAX_ADDRESS  = 31,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  err_valid,
  input  logic                  err_ready,
  output logic [1:0]            err_phase,
  output logic [ADDR_WIDTH-1:0] err_address,
  output logic [DATA_WIDTH-1:0] err_expected,
  output logic [DATA_WIDTH-1:0] err_actual,
  output logic [15:0]           pass_count,
  output logic [7:0]            error_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_P = 3'd1,
    S_RD_P = 3'd2,
    S_WR_N = 3'd3,
    S_RD_N = 3'd4,
    S_ERR  = 3'd5,
    S_END  = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDRESS);
  localparam logic [1:0]            RD_LAST   = 2'(READ_LATENCY);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic [1:0]              rd_cnt, rd_cnt_n;
  logic                    done_n;
  logic                    clr_counts;
  logic                    mismatch;
  logic                    accept;
  logic                    pass_inc;
  logic                    last_addr;
  logic                    neg_phase;
  logic [DATA_WIDTH-1:0]   pat;
  logic [DATA_WIDTH-1:0]   exp_word;

  // P(a) = {~a[0], a}; the negative phases use its complement.
  assign pat       = {~addr[0], addr};
  assign neg_phase = (state == S_WR_N) || (state == S_RD_N);
  assign exp_word  = neg_phase ? ~pat : pat;
  assign last_addr = (addr == LAST_ADDR);

  assign busy              = (state != S_IDLE);
  assign mem_write_enable  = (state == S_WR_P) || (state == S_WR_N);
  assign mem_write_address = addr;
  assign mem_write_data    = mem_write_enable ? exp_word : '0;
  assign mem_read_address  = addr;
  assign dbg_state         = state;

  // Error record handshake: err_valid rises the cycle after a mismatch and
  // holds, with every err_* field stable, until a cycle with err_valid &&
  // err_ready; the record is consumed on that clock edge.
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    rd_cnt_n   = rd_cnt;
    done_n     = 1'b0;
    clr_counts = 1'b0;
    mismatch   = 1'b0;
    accept     = 1'b0;
    pass_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_WR_P;
          addr_n     = '0;
          rd_cnt_n   = '0;
          clr_counts = 1'b1;
        end
      end
      S_WR_P, S_WR_N: begin
        if (last_addr) begin
          addr_n  = '0;
          state_n = (state == S_WR_P) ? S_RD_P : S_RD_N;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      S_RD_P, S_RD_N: begin
        if (rd_cnt == RD_LAST) begin
          rd_cnt_n = '0;
          if (mem_read_data != exp_word) begin
            mismatch = 1'b1;
            state_n  = S_ERR;
          end else if (last_addr) begin
            addr_n  = '0;
            state_n = (state == S_RD_P) ? S_WR_N : S_END;
          end else begin
            addr_n = addr + 1'b1;
          end
        end else begin
          rd_cnt_n = rd_cnt + 1'b1;
        end
      end
      S_ERR: begin
        if (err_valid && err_ready) begin
          accept = 1'b1;
          if (last_addr) begin
            addr_n  = '0;
            state_n = (err_phase == 2'd1) ? S_WR_N : S_END;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = (err_phase == 2'd1) ? S_RD_P : S_RD_N;
          end
        end
      end
      S_END: begin
        pass_inc = 1'b1;
        addr_n   = '0;
        if (continuous) begin
          state_n = S_WR_P;
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= S_IDLE;
      addr   <= '0;
      rd_cnt <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      rd_cnt <= rd_cnt_n;
      done   <= done_n;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_valid    <= 1'b0;
      err_phase    <= '0;
      err_address  <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else if (mismatch) begin
      err_valid    <= 1'b1;
      err_phase    <= (state == S_RD_P) ? 2'd1 : 2'd3;
      err_address  <= addr;
      err_expected <= exp_word;
      err_actual   <= mem_read_data;
    end else if (accept) begin
      err_valid <= 1'b0;
    end
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pass_count  <= '0;
      error_count <= '0;
    end else if (clr_counts) begin
      pass_count  <= '0;
      error_count <= '0;
    end else begin
      if (pass_inc && (pass_count != 16'hFFFF)) pass_count <= pass_count + 1'b1;
      if (mismatch && (error_count != 8'hFF)) error_count <= error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_march_ctrl.sv
// Directed bench for dram_march_ctrl with a behavioural LUT-RAM that can
// force bit 2 of address 5 low or high on read.
module tb_dram_march_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic       continuous;
  logic       busy;
  logic       done;
  logic [4:0] mem_write_address;
  logic [5:0] mem_write_data;
  logic       mem_write_enable;
  logic [4:0] mem_read_address;
  logic [5:0] mem_read_data;
  logic       err_valid;
  logic       err_ready;
  logic [1:0] err_phase;
  logic [4:0] err_address;
  logic [5:0] err_expected;
  logic [5:0] err_actual;
  logic [15:0] pass_count;
  logic [7:0]  error_count;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // 0: ideal, 1: addr 5 bit 2 stuck-at-0, 2: addr 5 bit 2 stuck-at-1
  int fault_mode = 0;

  logic [5:0] mem [32];

  int busy_cycles, done_pulses, ev_cycles, writes, wseq_bad, wr_idx;
  logic [4:0] exp_wa;
  logic [5:0] exp_wd;

  dram_march_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .continuous(continuous),
    .busy(busy), .done(done),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data), .err_valid(err_valid), .err_ready(err_ready),
    .err_phase(err_phase), .err_address(err_address),
    .err_expected(err_expected), .err_actual(err_actual),
    .pass_count(pass_count), .error_count(error_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: one-cycle registered read, optional stuck bit at address 5
  always @(posedge clk) begin
    logic [5:0] rd;
    if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    rd = mem[mem_read_address];
    if (mem_read_address == 5'd5 && fault_mode == 1) rd[2] = 1'b0;
    if (mem_read_address == 5'd5 && fault_mode == 2) rd[2] = 1'b1;
    mem_read_data <= rd;
  end

  // write-stream monitor: addresses 0..31 ascending, P(a) then ~P(a)
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (done) done_pulses++;
    if (err_valid) ev_cycles++;
    if (mem_write_enable) begin
      exp_wd = {~exp_wa[0], exp_wa};
      if (((wr_idx / 32) % 2) == 1) exp_wd = ~exp_wd;
      if (mem_write_address != exp_wa || mem_write_data != exp_wd) wseq_bad++;
      exp_wa = exp_wa + 5'd1;
      wr_idx++;
      writes++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    busy_cycles = 0; done_pulses = 0; ev_cycles = 0;
    writes = 0; wseq_bad = 0; wr_idx = 0; exp_wa = 5'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, done, 1'b1);
    tick();
  endtask

  initial begin
    logic [4:0] ra0;
    logic [4:0] wa0;
    logic [5:0] ea0, ex0;
    int n;
    int unstable;
    int we_seen;
    int writes_snap;

    for (int i = 0; i < 32; i++) mem[i] = 6'h00;
    nrst = 1'b0; start = 1'b0; continuous = 1'b0; err_ready = 1'b1;
    clear_mon();
    tick(); tick();

    // reset state
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_we", mem_write_enable, 1'b0);
    check_eq("rst_wa", mem_write_address, 5'd0);
    check_eq("rst_wd", mem_write_data, 6'd0);
    check_eq("rst_ra", mem_read_address, 5'd0);
    check_eq("rst_ev", err_valid, 1'b0);
    check_eq("rst_efields", {err_phase, err_address, err_expected, err_actual}, 19'd0);
    check_eq("rst_pass", pass_count, 16'd0);
    check_eq("rst_errc", error_count, 8'd0);
    check_eq("rst_state", dbg_state, 3'd0);
    nrst = 1'b1;
    tick();

    // single clean pass
    clear_mon();
    pulse_start();
    wait_done("t2_done_seen", 400);
    check_eq("t2_busy_cycles", busy_cycles, 193);
    check_eq("t2_done_pulses", done_pulses, 1);
    check_eq("t2_pass", pass_count, 16'd1);
    check_eq("t2_errc", error_count, 8'd0);
    check_eq("t2_ev_cycles", ev_cycles, 0);
    check_eq("t2_writes", writes, 64);
    check_eq("t2_wseq", wseq_bad, 0);
    check_eq("t2_idle", busy, 1'b0);

    // stuck-at-0 on bit 2 at address 5: phase-1 error, consumed at once
    fault_mode = 1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!err_valid && n < 400) begin tick(); n++; end
    check_eq("t3_ev_seen", err_valid, 1'b1);
    check_eq("t3_phase", err_phase, 2'd1);
    check_eq("t3_addr", err_address, 5'd5);
    check_eq("t3_exp", err_expected, 6'h05);
    check_eq("t3_act", err_actual, 6'h01);
    wait_done("t3_done_seen", 400);
    check_eq("t3_errc", error_count, 8'd1);
    check_eq("t3_pass", pass_count, 16'd1);
    check_eq("t3_busy_cycles", busy_cycles, 194);
    check_eq("t3_ev_cycles", ev_cycles, 1);

    // stuck-at-1: phase-3 error, record held 20 cycles before acceptance
    fault_mode = 2;
    err_ready = 1'b0;
    clear_mon();
    pulse_start();
    n = 0;
    while (!err_valid && n < 400) begin tick(); n++; end
    check_eq("t4_ev_seen", err_valid, 1'b1);
    check_eq("t4_phase", err_phase, 2'd3);
    check_eq("t4_addr", err_address, 5'd5);
    check_eq("t4_exp", err_expected, 6'h3A);
    check_eq("t4_act", err_actual, 6'h3E);
    ra0 = mem_read_address; wa0 = mem_write_address;
    ea0 = err_expected; ex0 = err_actual;
    unstable = 0; we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!err_valid || err_phase != 2'd3 || err_address != 5'd5 ||
          err_expected != ea0 || err_actual != ex0 ||
          mem_read_address != ra0 || mem_write_address != wa0) unstable++;
      if (mem_write_enable) we_seen++;
    end
    check_eq("t4_stable", unstable, 0);
    check_eq("t4_no_write", we_seen, 0);
    check_eq("t4_ra_frozen", ra0, 5'd5);
    err_ready = 1'b1;
    tick();
    check_eq("t4_ev_drop", err_valid, 1'b0);
    check_eq("t4_resume_ra", mem_read_address, 5'd6);
    check_eq("t4_resume_state", dbg_state, 3'd4);
    wait_done("t4_done_seen", 400);
    check_eq("t4_errc", error_count, 8'd1);
    check_eq("t4_pass", pass_count, 16'd1);

    // continuous for 3 passes, then a final 4th
    fault_mode = 0;
    continuous = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (pass_count != 16'd3 && n < 800) begin tick(); n++; end
    check_eq("t5_pass3_seen", pass_count, 16'd3);
    continuous = 1'b0;
    wait_done("t5_done_seen", 400);
    check_eq("t5_pass", pass_count, 16'd4);
    check_eq("t5_done_pulses", done_pulses, 1);
    check_eq("t5_writes", writes, 256);
    check_eq("t5_wseq", wseq_bad, 0);
    check_eq("t5_busy_cycles", busy_cycles, 772);
    check_eq("t5_errc", error_count, 8'd0);

    // reset during WR_N at address 10
    clear_mon();
    pulse_start();
    n = 0;
    while (!(dbg_state == 3'd3 && mem_write_address == 5'd10) && n < 400) begin tick(); n++; end
    check_eq("t6_reached", {dbg_state, mem_write_address}, {3'd3, 5'd10});
    nrst = 1'b0;
    #1;
    check_eq("t6_we", mem_write_enable, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_wa", mem_write_address, 5'd0);
    check_eq("t6_wd", mem_write_data, 6'd0);
    check_eq("t6_state", dbg_state, 3'd0);
    tick();
    nrst = 1'b1;
    writes_snap = writes;
    repeat (10) tick();
    check_eq("t6_stay_idle", busy, 1'b0);
    check_eq("t6_no_writes", writes, writes_snap);

    // start while in RD_P is ignored
    clear_mon();
    pulse_start();
    n = 0;
    while (dbg_state != 3'd2 && n < 400) begin tick(); n++; end
    check_eq("t7_in_rdp", dbg_state, 3'd2);
    repeat (5) tick();
    pulse_start();
    wait_done("t7_done_seen", 400);
    check_eq("t7_busy_cycles", busy_cycles, 193);
    check_eq("t7_pass", pass_count, 16'd1);
    check_eq("t7_done_pulses", done_pulses, 1);
    check_eq("t7_wseq", wseq_bad, 0);
    check_eq("t7_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
